// File: rtl/multdiv_unit_if.sv
// rtl/multdiv_unit_if.sv - start/operand/result bundle between the execute stage and multdiv_unit
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - fixed-latency signed shift-add multiplier / restoring divider
// Define MULTDIV_DIV_EN to build the divider; otherwise a divide returns 0 with exception set.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          ctrl_reset,
  multdiv_unit_if.slave mdu
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             op_div_q;
  logic             neg_q;
  logic [WIDTH-1:0] bmag_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy;
  logic             busy;

  logic             start;
  logic             start_div;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign start     = mdu.ctrl_MULT | mdu.ctrl_DIV;
  assign start_div = mdu.ctrl_DIV & ~mdu.ctrl_MULT;
  assign last_iter = (state_q == RUN) && (cnt_q == LAST_ITER);
  assign a_mag     = mdu.data_operandA[WIDTH-1] ? -mdu.data_operandA : mdu.data_operandA;
  assign b_mag     = mdu.data_operandB[WIDTH-1] ? -mdu.data_operandB : mdu.data_operandB;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // A start pulse preempts whatever is in flight.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (last_iter) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rdy  = (state_q == DONE);
    busy = (state_q != IDLE);
  end

  // {hi,lo} holds accumulator/multiplier for multiply, remainder/dividend-quotient for divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : '0);

`ifdef MULTDIV_DIV_EN
  logic             bzero_q;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, bmag_q};
`endif

  always_comb begin
    hi_step = mul_sum[WIDTH:1];
    lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULTDIV_DIV_EN
    if (op_div_q) begin
      hi_step = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end
`endif
  end

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic               mul_exc;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_exc;

  assign prod_mag = {hi_step, lo_step};
  assign prod     = neg_q ? -prod_mag : prod_mag;
  // The product fits iff its upper WIDTH+1 bits are a pure sign extension.
  assign mul_exc  = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));

  always_comb begin
    fin_res = prod[WIDTH-1:0];
    fin_exc = mul_exc;
    if (op_div_q) begin
`ifdef MULTDIV_DIV_EN
      if (bzero_q) begin
        fin_res = '0;
        fin_exc = 1'b1;
      end else begin
        fin_res = neg_q ? -lo_step : lo_step;
        fin_exc = ~neg_q & lo_step[WIDTH-1];
      end
`else
      fin_res = '0;
      fin_exc = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      bmag_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
      bzero_q  <= 1'b0;
`endif
    end else if (start) begin
      cnt_q    <= '0;
      op_div_q <= start_div;
      neg_q    <= mdu.data_operandA[WIDTH-1] ^ mdu.data_operandB[WIDTH-1];
      bmag_q   <= b_mag;
      hi_q     <= '0;
      lo_q     <= a_mag;
`ifdef MULTDIV_DIV_EN
      bzero_q  <= (mdu.data_operandB == '0);
`endif
    end else if (state_q == RUN) begin
      cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      if (last_iter) begin
        result_q <= fin_res;
        exc_q    <= fin_exc;
      end
    end
  end

  assign mdu.data_result    = result_q;
  assign mdu.data_exception = exc_q;
  assign mdu.data_resultRDY = rdy;
  assign mdu.busy           = busy;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - randomized self-checking bench for multdiv_unit against an arithmetic model
module tb_multdiv_unit;
  logic clock = 1'b0;
  logic ctrl_reset;

  always #5 clock = ~clock;

  multdiv_unit_if #(.WIDTH(32)) bus ();

  multdiv_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .mdu        (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_res;
  bit          last_exc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    longint p;
    if (!is_div) begin
      p = sa * sb;
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else begin
`ifdef MULTDIV_DIV_EN
      if (sb == 0) begin
        r = 32'h0;
        e = 1'b1;
      end else begin
        p = sa / sb;
        r = p[31:0];
        e = (p > 64'sd2147483647);
      end
`else
      r = 32'h0;
      e = 1'b1;
`endif
    end
  endfunction

  // Drives a start at the current negedge; returns at the negedge inside the DONE cycle.
  task automatic run_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    bit          ee;
    int          n;
    model(!mul, a, b, er, ee);
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.data_resultRDY && n < 40) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    check("latency", 64'(n), 64'd32);
    check("result", 64'(bus.data_result), 64'(er));
    check("exception", 64'(bus.data_exception), 64'(ee));
    check("busy_done", 64'(bus.busy), 64'd1);
    last_res = er;
    last_exc = ee;
  endtask

  task automatic idle_cycle();
    @(posedge clock);
    @(negedge clock);
    check("rdy_pulse_end", 64'(bus.data_resultRDY), 64'd0);
    check("result_hold", 64'(bus.data_result), 64'(last_res));
    check("exc_hold", 64'(bus.data_exception), 64'(last_exc));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 200)) - 32'd100;
      2:       v = 32'h8000_0000;
      3:       v = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'hFFFF_FFFF;
      default: v = 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
    endcase
    return v;
  endfunction

  initial begin
    bit seen;
    int op;
    ctrl_reset        = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #12;
    check("reset_result", 64'(bus.data_result), 64'd0);
    check("reset_exc", 64'(bus.data_exception), 64'd0);
    check("reset_rdy", 64'(bus.data_resultRDY), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    @(negedge clock);
    ctrl_reset = 1'b0;

    run_op(1, 0, 32'd7, -32'sd6);                idle_cycle();
    run_op(1, 0, 32'h7FFF_FFFF, 32'd2);          idle_cycle();
    run_op(1, 0, 32'h0001_0000, 32'h0001_0000);  idle_cycle();
    run_op(0, 1, -32'sd7, 32'd2);                idle_cycle();
    run_op(0, 1, 32'd5, 32'd0);                  idle_cycle();
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);  idle_cycle();
    run_op(1, 1, 32'd9, 32'd9);
    run_op(0, 1, 32'd100, 32'd7);
    idle_cycle();

    // Abort a multiply 10 cycles in; only the second one may report.
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd4;
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.data_resultRDY) seen = 1'b1;
    end
    check("restart_no_early_rdy", 64'(seen), 64'd0);
    run_op(1, 0, 32'd5, 32'd5);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      run_op(op != 1, op != 0, rand_operand(), rand_operand());
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();

    // Asynchronous reset in the middle of a run.
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd6;
    bus.data_operandB = 32'd7;
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    repeat (10) @(negedge clock);
    #2 ctrl_reset = 1'b1;
    #1;
    check("midrun_reset_result", 64'(bus.data_result), 64'd0);
    check("midrun_reset_exc", 64'(bus.data_exception), 64'd0);
    check("midrun_reset_rdy", 64'(bus.data_resultRDY), 64'd0);
    check("midrun_reset_busy", 64'(bus.busy), 64'd0);
    @(negedge clock);
    ctrl_reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.data_resultRDY || bus.busy) seen = 1'b1;
    end
    check("post_reset_quiet", 64'(seen), 64'd0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    @(negedge clock);
    ctrl_reset = 1'b0;
    run_op(1, 0, -32'sd12, -32'sd12);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
